moxie_issue_ctrl: RTL and testbench

MOXIE_ISSUE_CTRL -- requirements
Module: moxie_issue_ctrl

---
 rtl/moxie_issue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_moxie_issue_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moxie_issue_ctrl.sv
// moxie_issue_ctrl: opcode issue controller for the moxie pipeline.
// Walks each accepted instruction through IMM -> MULTI -> MEM -> ISSUE,
// skipping any phase whose microcode class bit is clear.
// Optional feature macro: MOXIE_ISSUE_PERF_EN adds the stall_count_o
// performance counter.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are high. Valid must not depend combinationally on ready;
// once issue_valid_o is raised, opcode/imm/class hold until ex_ready_i.
// flush_i overrides any handshake in the same cycle.
module moxie_issue_ctrl #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  opcode_i,
  input  logic [2:0]  ucode_i,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic [31:0] imm_i,
  input  logic        imm_valid_i,
  input  logic        mem_ack_i,
  input  logic        ex_ready_i,
  input  logic        flush_i,
  output logic        issue_valid_o,
  output logic [7:0]  issue_opcode_o,
  output logic [31:0] issue_imm_o,
  output logic [2:0]  issue_class_o,
  output logic        mem_req_o,
  output logic        busy_o,
`ifdef MOXIE_ISSUE_PERF_EN
  output logic [31:0] stall_count_o,
`endif
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IMM   = 3'd1,
    S_MULTI = 3'd2,
    S_MEM   = 3'd3,
    S_ISSUE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q;
  logic       accept;
  logic       load_imm;

  // Phase following IMM for a given class.
  function automatic state_t after_imm(input logic [2:0] cls);
    if (cls[1])      return S_MULTI;
    else if (cls[0]) return S_MEM;
    else             return S_ISSUE;
  endfunction

  // Phase following MULTI for a given class.
  function automatic state_t after_multi(input logic [2:0] cls);
    return cls[0] ? S_MEM : S_ISSUE;
  endfunction

  assign busy_o      = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

  // Next-state, acceptance and immediate-capture decisions; flush wins.
  always_comb begin
    state_d    = state_q;
    op_ready_o = 1'b0;
    accept     = 1'b0;
    load_imm   = 1'b0;
    case (state_q)
      S_IDLE: begin
        op_ready_o = ~flush_i;
        if (op_valid_i) begin
          accept  = 1'b1;
          state_d = ucode_i[2] ? S_IMM : after_imm(ucode_i);
        end
      end
      S_IMM: begin
        if (imm_valid_i) begin
          load_imm = 1'b1;
          state_d  = after_imm(issue_class_o);
        end
      end
      S_MULTI: begin
        if (cnt_q == 5'd0) state_d = after_multi(issue_class_o);
      end
      S_MEM: begin
        if (mem_ack_i) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (ex_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d  = S_IDLE;
      accept   = 1'b0;
      load_imm = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Instruction latches: opcode/class on accept, immediate in IMM.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      issue_opcode_o <= 8'd0;
      issue_class_o  <= 3'd0;
      issue_imm_o    <= 32'd0;
    end else if (accept) begin
      issue_opcode_o <= opcode_i;
      issue_class_o  <= ucode_i;
      issue_imm_o    <= 32'd0;
    end else if (load_imm) begin
      issue_imm_o    <= imm_i;
    end
  end

  // Registered strobes derived from the next state, never from raw inputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      issue_valid_o <= 1'b0;
      mem_req_o     <= 1'b0;
    end else begin
      issue_valid_o <= (state_d == S_ISSUE);
      mem_req_o     <= (state_d == S_MEM);
    end
  end

  // MULTI dwell counter: loaded on entry, counts down to zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= 5'd0;
    end else if (state_d == S_MULTI && state_q != S_MULTI) begin
      cnt_q <= 5'(MULDIV_CYCLES - 1);
    end else if (state_q == S_MULTI && cnt_q != 5'd0) begin
      cnt_q <= cnt_q - 5'd1;
    end
  end

`ifdef MOXIE_ISSUE_PERF_EN
  logic issue_hs;
  assign issue_hs = (state_q == S_ISSUE) & ex_ready_i & ~flush_i;

  // Saturating count of busy cycles without an issue handshake.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_count_o <= 32'd0;
    end else if (busy_o && !issue_hs && stall_count_o != 32'hFFFF_FFFF) begin
      stall_count_o <= stall_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_moxie_issue_ctrl.sv
// Testbench for moxie_issue_ctrl: directed scenarios plus random traffic,
// checked against a phase-queue reference model and an issue scoreboard.
module tb_moxie_issue_ctrl;

  localparam int CYC = 4;
  localparam int PH_NONE = 0, PH_IMM = 1, PH_MULTI = 2, PH_MEM = 3, PH_ISSUE = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic [7:0]  opcode_i;
  logic [2:0]  ucode_i;
  logic        op_valid_i, op_ready_o;
  logic [31:0] imm_i;
  logic        imm_valid_i, mem_ack_i, ex_ready_i, flush_i;
  logic        issue_valid_o;
  logic [7:0]  issue_opcode_o;
  logic [31:0] issue_imm_o;
  logic [2:0]  issue_class_o;
  logic        mem_req_o, busy_o;
  logic [2:0]  dbg_state_o;
`ifdef MOXIE_ISSUE_PERF_EN
  logic [31:0] stall_count_o;
`endif

  moxie_issue_ctrl #(.MULDIV_CYCLES(CYC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .opcode_i(opcode_i), .ucode_i(ucode_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .imm_i(imm_i), .imm_valid_i(imm_valid_i),
    .mem_ack_i(mem_ack_i), .ex_ready_i(ex_ready_i), .flush_i(flush_i),
    .issue_valid_o(issue_valid_o), .issue_opcode_o(issue_opcode_o),
    .issue_imm_o(issue_imm_o), .issue_class_o(issue_class_o),
    .mem_req_o(mem_req_o), .busy_o(busy_o),
`ifdef MOXIE_ISSUE_PERF_EN
    .stall_count_o(stall_count_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Each accepted instruction becomes a list of remaining phases; one MULTI
  // entry per cycle of dwell. The head entry is the current behaviour.
  int          mq[$];
  logic [7:0]  m_op;
  logic [2:0]  m_cls;
  logic [31:0] m_imm;
  longint      m_stall;
  logic [42:0] exp_q[$];
  int          n_hs;

  // Next stimulus values.
  logic        d_op_valid, d_imm_valid, d_ack, d_ex_ready, d_flush;
  logic [7:0]  d_op;
  logic [2:0]  d_uc;
  logic [31:0] d_imm;

  function automatic int front();
    return (mq.size() != 0) ? mq[0] : PH_NONE;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_op = '0; m_cls = '0; m_imm = '0; m_stall = 0;
  endtask

  task automatic model_step();
    if (!rst_i) begin
      model_reset();
    end else begin
      if (mq.size() != 0 && !(front() == PH_ISSUE && d_ex_ready && !d_flush))
        if (m_stall < 64'hFFFF_FFFF) m_stall++;
      if (d_flush) begin
        mq.delete();
      end else if (mq.size() == 0) begin
        if (d_op_valid) begin
          m_op = d_op; m_cls = d_uc; m_imm = '0;
          if (d_uc[2]) mq.push_back(PH_IMM);
          if (d_uc[1]) for (int i = 0; i < CYC; i++) mq.push_back(PH_MULTI);
          if (d_uc[0]) mq.push_back(PH_MEM);
          mq.push_back(PH_ISSUE);
        end
      end else begin
        case (front())
          PH_IMM:   if (d_imm_valid) begin m_imm = d_imm; void'(mq.pop_front()); end
          PH_MULTI: void'(mq.pop_front());
          PH_MEM:   if (d_ack) void'(mq.pop_front());
          PH_ISSUE: if (d_ex_ready) begin
                      exp_q.push_back({m_cls, m_imm, m_op});
                      void'(mq.pop_front());
                    end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_outputs();
    check("issue_valid", issue_valid_o, front() == PH_ISSUE);
    check("mem_req", mem_req_o, front() == PH_MEM);
    check("busy", busy_o, mq.size() != 0);
    check("opcode", issue_opcode_o, m_op);
    check("class", issue_class_o, m_cls);
    check("imm", issue_imm_o, m_imm);
`ifdef MOXIE_ISSUE_PERF_EN
    check("stall_count", stall_count_o, m_stall[31:0]);
`endif
  endtask

  // ---------------- driver ----------------
  task automatic set_idle();
    d_op_valid = 0; d_op = '0; d_uc = '0; d_imm = '0;
    d_imm_valid = 0; d_ack = 0; d_ex_ready = 0; d_flush = 0;
  endtask

  task automatic apply();
    op_valid_i = d_op_valid; opcode_i = d_op; ucode_i = d_uc; imm_i = d_imm;
    imm_valid_i = d_imm_valid; mem_ack_i = d_ack; ex_ready_i = d_ex_ready;
    flush_i = d_flush;
  endtask

  // One clock: check registered outputs, drive inputs, check op_ready,
  // advance the model, then score any issue handshake on the coming edge.
  task automatic tick();
    logic [42:0] e;
    @(negedge clk);
    check_outputs();
    apply();
    #1;
    check("op_ready", op_ready_o, (mq.size() == 0) && !d_flush);
    model_step();
    if (rst_i && issue_valid_o && ex_ready_i && !flush_i) begin
      n_hs++;
      check("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_opcode", issue_opcode_o, e[7:0]);
        check("sb_imm", issue_imm_o, e[39:8]);
        check("sb_class", issue_class_o, e[42:40]);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int          cnt_mem, cnt_iss, cnt_multi, hs0;
  logic        v4, v5;
  longint      s0;

  initial begin
    n_hs = 0;
    set_idle();
    apply();
    rst_i = 1'b0;
    #2;
    check("rst_issue_valid", issue_valid_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_opcode", issue_opcode_o, 0);
    check("rst_imm", issue_imm_o, 0);
    check("rst_class", issue_class_o, 0);
`ifdef MOXIE_ISSUE_PERF_EN
    check("rst_stall", stall_count_o, 0);
`endif
    model_reset();
    @(posedge clk); #1 rst_i = 1'b1;

    // Class 000: issue one cycle after acceptance, back to idle after.
    set_idle(); d_op_valid = 1; d_op = 8'h05; d_ex_ready = 1;
    tick();
    set_idle(); d_ex_ready = 1;
    tick();
    check("c000_valid", issue_valid_o, 1);
    check("c000_opcode", issue_opcode_o, 8'h05);
    check("c000_imm", issue_imm_o, 0);
    tick();
    check("c000_idle", busy_o, 0);
    check("c000_valid_drop", issue_valid_o, 0);

    // Class 010: MULTI dwell of CYC cycles, issue on cycle CYC+1.
    set_idle(); d_op_valid = 1; d_op = 8'h31; d_uc = 3'b010;
    tick();
    set_idle();
    cnt_multi = 0; v4 = 0; v5 = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (busy_o && !issue_valid_o && !mem_req_o) cnt_multi++;
      if (k == 4) v4 = issue_valid_o;
      if (k == 5) v5 = issue_valid_o;
    end
    check("c010_multi_cycles", cnt_multi, CYC);
    check("c010_valid_c4", v4, 0);
    check("c010_valid_c5", v5, 1);
    d_ex_ready = 1; tick(); set_idle(); tick();

    // Class 111: immediate 3 cycles late, ack on 2nd MEM cycle.
    set_idle(); d_op_valid = 1; d_op = 8'hC7; d_uc = 3'b111;
    tick();
    cnt_mem = 0; cnt_iss = 0;
    for (int k = 1; k <= 14; k++) begin
      set_idle();
      d_imm_valid = (k == 3);
      d_imm = (k == 3) ? 32'hDEADBEEF : $urandom;
      d_ack = (k == 9);
      d_ex_ready = (k >= 10);
      tick();
      if (mem_req_o) cnt_mem++;
      if (issue_valid_o) cnt_iss++;
    end
    check("c111_imm", issue_imm_o, 32'hDEADBEEF);
    check("c111_mem_cycles", cnt_mem, 2);
    check("c111_issue_cycles", cnt_iss, 1);

    // Flush in MEM with simultaneous ack.
    set_idle(); d_op_valid = 1; d_op = 8'h33; d_uc = 3'b001;
    tick();
    set_idle(); d_flush = 1; d_ack = 1; d_ex_ready = 1;
    tick();
    check("flush_in_mem_req", mem_req_o, 1);
    set_idle();
    tick();
    check("flush_valid", issue_valid_o, 0);
    check("flush_busy", busy_o, 0);
    check("flush_mem_req", mem_req_o, 0);
    check("flush_op_ready", op_ready_o, 1);

    // ISSUE held 5 cycles with ex_ready low.
    set_idle(); d_op_valid = 1; d_op = 8'h34;
    tick();
    set_idle();
    tick();
    s0 = m_stall;
    for (int k = 2; k <= 6; k++) begin
      tick();
      check("hold_valid", issue_valid_o, 1);
      check("hold_opcode", issue_opcode_o, 8'h34);
      check("hold_class", issue_class_o, 0);
      check("hold_imm", issue_imm_o, 0);
    end
`ifdef MOXIE_ISSUE_PERF_EN
    check("hold_stall_delta", stall_count_o, s0 + 5);
`endif
    d_ex_ready = 1; tick(); set_idle(); tick();

    // Asynchronous reset mid-MULTI.
    set_idle(); d_op_valid = 1; d_op = 8'h2A; d_uc = 3'b010;
    tick();
    set_idle(); d_ex_ready = 1;
    tick(); tick();
    hs0 = n_hs;
    #2 rst_i = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_valid", issue_valid_o, 0);
    check("arst_mem_req", mem_req_o, 0);
    check("arst_opcode", issue_opcode_o, 0);
    check("arst_class", issue_class_o, 0);
    model_reset();
    tick(); tick();
    @(posedge clk); #1 rst_i = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check("arst_no_issue", n_hs, hs0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      d_op_valid  = 1'($urandom_range(0, 1));
      d_op        = 8'($urandom);
      d_uc        = 3'($urandom_range(0, 7));
      d_imm       = $urandom;
      d_imm_valid = ($urandom_range(0, 9) < 3);
      d_ack       = ($urandom_range(0, 9) < 3);
      d_ex_ready  = ($urandom_range(0, 9) < 5);
      d_flush     = ($urandom_range(0, 19) == 0);
      tick();
    end

    // Drain and final scoreboard check.
    set_idle(); d_ex_ready = 1; d_ack = 1; d_imm_valid = 1;
    for (int k = 0; k < 30; k++) tick();
    check("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
